// File: rtl/scan_controller_if.sv
// Host handshake plus scan-chain pins of the scan controller.
// master = host/chain side, slave = controller side.
interface scan_controller_if #(
  parameter int NUM_IOS = 8,
  parameter int SEL_W   = 8
);
  logic               start;
  logic [SEL_W-1:0]   active_select;
  logic [NUM_IOS-1:0] inputs;
  logic [NUM_IOS-1:0] outputs;
  logic               busy;
  logic               done;
  logic               err;
  logic               scan_clk;
  logic               scan_data_out;
  logic               scan_select;
  logic               scan_latch_en;
  logic               scan_data_in;

  modport master (
    output start, active_select, inputs, scan_data_in,
    input  outputs, busy, done, err, scan_clk, scan_data_out, scan_select, scan_latch_en
  );

  modport slave (
    input  start, active_select, inputs, scan_data_in,
    output outputs, busy, done, err, scan_clk, scan_data_out, scan_select, scan_latch_en
  );
endinterface

// File: rtl/scan_controller.sv
// Scan-chain master: shifts a byte into one chain element, latches it, captures
// that element's outputs and shifts them back to the host.
module scan_controller #(
  parameter int NUM_DESIGNS  = 4,
  parameter int NUM_IOS      = 8,
  parameter int CLK_DIV      = 2,
  parameter int LATCH_CYCLES = 2,
  parameter int SEL_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  scan_controller_if.slave bus
);
  localparam int KW = (NUM_DESIGNS > 1) ? $clog2(NUM_DESIGNS) : 1;
  localparam int CW = $clog2(NUM_DESIGNS * NUM_IOS + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SHIFT_IN  = 3'd1;
  localparam logic [2:0] LATCH     = 3'd2;
  localparam logic [2:0] CAPTURE   = 3'd3;
  localparam logic [2:0] SHIFT_OUT = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DESIGNS - 1);
  localparam logic [DW-1:0]    DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0]    LAT_LAST = LW'(LATCH_CYCLES - 1);

  logic [2:0]         state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LW-1:0]      lat_q, lat_d;
  logic [KW-1:0]      k_q, k_d;
  logic [NUM_IOS-1:0] in_q, in_d;
  logic [NUM_IOS-1:0] sh_q, sh_d;
  logic [NUM_IOS-1:0] out_q, out_d;
  logic               sclk_q, sclk_d;
  logic               sdo_q, sdo_d;
  logic               sel_q, sel_d;
  logic               latch_q, latch_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               phase_end_s;
  logic               scanning_s;
  logic [CW-1:0]      last_in_s;
  logic [CW-1:0]      skip_s;
  logic [CW-1:0]      last_out_s;
  logic [NUM_IOS-1:0] sh_next_s;

  // Pulse/slot targets depend only on the captured design index
  always_comb begin
    scanning_s  = (state_q == SHIFT_IN) || (state_q == CAPTURE) || (state_q == SHIFT_OUT);
    phase_end_s = (div_q == DIV_LAST);
    last_in_s   = (CW'(k_q) + CW'(1)) * CW'(NUM_IOS);
    skip_s      = (CW'(NUM_DESIGNS - 1) - CW'(k_q)) * CW'(NUM_IOS);
    last_out_s  = skip_s + CW'(NUM_IOS - 1);
    sh_next_s   = NUM_IOS'({sh_q, bus.scan_data_in});
  end

  // Next-state logic for the transaction sequencer and scan clock divider
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    k_d     = k_q;
    in_d    = in_q;
    sh_d    = sh_q;
    out_d   = out_q;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    sel_d   = sel_q;
    latch_d = latch_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (scanning_s && !phase_end_s) begin
      div_d = div_q + DW'(1);
    end else begin
      div_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.active_select <= LAST_SEL)) begin
          k_d     = KW'(bus.active_select);
          sdo_d   = bus.inputs[NUM_IOS-1];
          in_d    = NUM_IOS'({bus.inputs, 1'b0});
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT_IN;
        end else if (bus.start) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT_IN: begin
        if (phase_end_s && !sclk_q) begin
          sclk_d = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end else if (phase_end_s) begin
          sclk_d = 1'b0;
          if (cnt_q == last_in_s) begin
            sdo_d   = 1'b0;
            cnt_d   = '0;
            lat_d   = '0;
            latch_d = 1'b1;
            state_d = LATCH;
          end else begin
            sdo_d = in_q[NUM_IOS-1];
            in_d  = NUM_IOS'({in_q, 1'b0});
          end
        end else begin
          sclk_d = sclk_q;
        end
      end
      LATCH: begin
        // One low cycle separates the latch window from the capture select
        if (latch_q && (lat_q == LAT_LAST)) begin
          latch_d = 1'b0;
        end else if (latch_q) begin
          lat_d = lat_q + LW'(1);
        end else begin
          sel_d   = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (phase_end_s && !sclk_q) begin
          sclk_d = 1'b1;
        end else if (phase_end_s) begin
          sclk_d  = 1'b0;
          sel_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT_OUT;
        end else begin
          sclk_d = sclk_q;
        end
      end
      SHIFT_OUT: begin
        // cnt_q numbers the sample slots; the first skip_s belong to downstream designs
        if (phase_end_s && !sclk_q) begin
          if (cnt_q >= skip_s) begin
            sh_d = sh_next_s;
          end else begin
            sh_d = sh_q;
          end
          if (cnt_q == last_out_s) begin
            out_d   = sh_next_s;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            sclk_d = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end
        end else if (phase_end_s) begin
          sclk_d = 1'b0;
        end else begin
          sclk_d = sclk_q;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        sclk_d  = 1'b0;
        sdo_d   = 1'b0;
        sel_d   = 1'b0;
        latch_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      k_q     <= '0;
      in_q    <= '0;
      sh_q    <= '0;
      out_q   <= '0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      sel_q   <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      k_q     <= k_d;
      in_q    <= in_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      sel_q   <= sel_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.outputs       = out_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.scan_clk      = sclk_q;
  assign bus.scan_data_out = sdo_q;
  assign bus.scan_select   = sel_q;
  assign bus.scan_latch_en = latch_q;
endmodule

// File: doc/scan_controller.md
Name: scan_controller

Overview:
- Master for the daisy-chained 8-bit scan chain elements; drives the chain's clock, data, select and latch lines, and receives serial data from the chain's far end.
- One transaction drives an 8-bit input byte into one selected design and latches it there, then captures that design's 8-bit output and shifts it back to the controller.
- Sits between the top-level I/O (or a host register block) and chain element 0; the last element's data_out loops back to scan_data_in.

Parameters:
NUM_DESIGNS, 4, number of chain elements (designs) on the chain, >=1
NUM_IOS, 8, bits per chain element
CLK_DIV, 2, clk cycles per scan_clk half-period, >=1
LATCH_CYCLES, 2, clk cycles scan_latch_en is held high, >=1
SEL_W, 8, width of active_select

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high
start  input  1  begin a transaction; sampled only in IDLE
active_select  input  SEL_W  index of target design, 0 = first element after controller
inputs  input  NUM_IOS  byte to drive into target design; captured at start
outputs  output  NUM_IOS  last byte read back from target design
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when outputs updated
err  output  1  one-cycle pulse when start rejected
scan_clk  output  1  chain clock
scan_data_out  output  1  serial data to chain element 0
scan_select  output  1  chain select; high = capture module outputs on scan_clk rise
scan_latch_en  output  1  chain latch enable; high = chain flops transparent to designs
scan_data_in  input  1  serial data from last chain element (changes after scan_clk fall)

Behaviour:
- Reset (async): state IDLE; outputs=0, busy=0, done=0, err=0, scan_clk=0, scan_data_out=0, scan_select=0, scan_latch_en=0; all counters 0. Reset mid-transaction aborts immediately; no partial outputs update.
- Scan bit timing: scan_clk low for CLK_DIV clk cycles, then high for CLK_DIV cycles. scan_data_out/scan_select change only on the clk edge where scan_clk goes low (or while idle-low). A "sample slot" is the last clk cycle of a low phase; scan_data_in is registered there.
- States: IDLE -> SHIFT_IN -> LATCH -> CAPTURE -> SHIFT_OUT -> DONE -> IDLE.
- IDLE: start=1 with active_select < NUM_DESIGNS: latch k=active_select and inputs; busy=1; go SHIFT_IN. If active_select >= NUM_DESIGNS: err pulses 1 cycle, stay IDLE. busy=1 blocks start; start is ignored outside IDLE.
- SHIFT_IN: scan_select=0; (k+1)*NUM_IOS scan_clk pulses. First NUM_IOS bits are inputs MSB first; remaining k*NUM_IOS bits are 0. Afterwards, design k's flops hold inputs (bit i at flop i), and designs 0..k-1 hold 0.
- LATCH: scan_clk=0; scan_latch_en=1 for exactly LATCH_CYCLES clk cycles, then 0 for one clk cycle before CAPTURE.
- CAPTURE: scan_select=1 for one full low phase, then one scan_clk pulse. scan_select returns to 0 on the edge where scan_clk falls.
- SHIFT_OUT: scan_select=0. D = (NUM_DESIGNS-1-k)*NUM_IOS. The first D sample slots are discarded. The next NUM_IOS sample slots hold the target's bits MSB first, shifted into an internal register.
  - A scan_clk pulse follows every sample slot except the final one.
  - Total pulses = D+NUM_IOS-1.
- DONE: on the cycle after the final sample slot, outputs is updated, done=1 for one cycle and busy=0; the next cycle is IDLE. start may be accepted on the cycle after done.
- Counters sized for NUM_DESIGNS*NUM_IOS; no wrap within a transaction.
- Edge case k=NUM_DESIGNS-1: D=0; the first sample slot after capture is bit NUM_IOS-1.

Test Plan:
- Bench: NUM_DESIGNS=4, CLK_DIV=1. Behavioural chain of 4 elements (posedge shift/capture, negedge data_out, transparent latch); each design drives ~input.
- k=0, inputs=8'hA5 -> design0 sees 8'hA5 after LATCH; outputs=8'h5A; done pulses once; designs 1-3 unchanged.
- k=3, inputs=8'h01 -> 32 SHIFT_IN pulses; design3 sees 8'h01; outputs=8'hFE; SHIFT_OUT has 7 pulses (D=0).
- active_select=4 with start -> err pulse, busy stays 0, no scan_clk activity, outputs unchanged.
- reset asserted mid-SHIFT_OUT of a k=1 transaction -> all outputs 0 immediately. A following k=1, inputs=8'h3C transaction completes with outputs=8'hC3.
- CLK_DIV=3, back-to-back starts with k=2 (8'hFF then 8'h00) -> outputs 8'h00 then 8'hFF. scan_clk high/low phases are exactly 3 clk cycles. start held during busy is ignored.
